pc_call_stack: RTL and testbench
================================

# pc_call_stack

Parametrised program counter with an integrated hardware return-address stack. It is the next generation of the single-level jump/return program counter, and adds several features: configurable address width, a configurable-depth call stack, PC-relative branching, a stall input, and overflow/underflow fault reporting. It drives the address input of the instruction memory directly and is steered by the control unit.

## Interface

Parameters:
- ADDR_WIDTH, 16, width of the PC, jump/branch operands and stack entries
- STACK_DEPTH, 8, number of return-address entries; must be ≥ 1
- RESET_VECTOR, 0, PC value loaded on reset
- INCREMENT, 1, sequential PC step per cycle

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset; one clock, reset is synchronous and active-low
- stall  input  1  hold PC and stack; all other controls ignored
- jump_enable  input  1  absolute jump to jump_address
- call_enable  input  1  push return address, jump to jump_address
- return_enable  input  1  pop top of stack into PC
- branch_enable  input  1  PC-relative branch by branch_offset
- jump_address  input  ADDR_WIDTH  target for jump and call
- branch_offset  input  ADDR_WIDTH  two's-complement offset for branch
- counter_reg  output  ADDR_WIDTH  current PC, registered
- stack_depth  output  clog2(STACK_DEPTH+1)  number of valid entries
- stack_full  output  1  stack_depth == STACK_DEPTH
- stack_empty  output  1  stack_depth == 0
- overflow  output  1  sticky; a call occurred while full
- underflow  output  1  sticky; a return occurred while empty

## Operation

- State:
  - PC register.
  - Stack array of STACK_DEPTH × ADDR_WIDTH.
  - Depth counter.
  - Two sticky fault bits.
- Per rising edge, the first true condition in this priority order applies:
  1. reset low: counter_reg=RESET_VECTOR, stack_depth=0, overflow=0, underflow=0. Stack contents are not cleared and are never observable while invalid.
  2. stall high: all state holds.
  3. return_enable:
     - Depth > 0: PC ← top entry, depth−1.
     - Depth == 0: PC ← PC+INCREMENT, underflow←1, depth stays 0.
  4. call_enable:
     - Not full: push PC+INCREMENT, depth+1, PC ← jump_address.
     - Full: push discarded, stack unchanged, PC ← jump_address, overflow←1.
  5. jump_enable: PC ← jump_address.
  6. branch_enable: PC ← PC + branch_offset.
  7. Otherwise: PC ← PC + INCREMENT.
- Simultaneous controls resolve by this priority. Lower-priority requests in the same cycle have no effect; for example, return+call pops only, and nothing is pushed.
- Arithmetic: all PC sums are modulo 2^ADDR_WIDTH. Overflow of the sum wraps silently and sets no flag. branch_offset is sign-interpreted; the result is the low ADDR_WIDTH bits of the sum.
- The stack is LIFO. Top entry = index depth−1.
- Sticky flags clear only on reset.
- stack_full and stack_empty decode the registered depth, so they change only on clock edges.

## Timing

- All outputs are registered or decoded from registers. No combinational path from any input to any output.
- Control asserted before edge N takes effect at edge N. The new counter_reg is valid after edge N and feeds the instruction memory for the following cycle.
- A call and its matching return are each single-cycle. A return issued one cycle after a call yields the call-site address + INCREMENT.
- Reset is sampled only on rising edges. Asserting reset mid-call or mid-return overrides that operation in the same cycle.
- After reset release, the first increment occurs at the first edge where reset is high and stall is low.
- Stall held for K cycles freezes counter_reg for K edges. A control present only while stall is high is lost.

## Test plan

- Reset and run (defaults): reset low 2 cycles → counter_reg=0, stack_empty=1, flags 0. Release reset → counter_reg steps 1,2,3… on successive edges.
- Call/return nesting:
  - At PC=3, call to 0x0040 → counter_reg=0x0040, stack_depth=1.
  - At 0x0041, call to 0x0080 → depth=2.
  - Return → 0x0042. Return → 0x0004, stack_empty=1.
- Overflow (STACK_DEPTH=4): 5 consecutive calls to 0x0100 starting at PC=0.
  - After the 4th call: stack_full=1.
  - After the 5th call: overflow=1, depth=4, PC=0x0100.
  - 4 returns then pop 0x0101,0x0101,0x0101,0x0001.
- Underflow and wrap:
  - Return when empty at PC=7 → PC=8, underflow=1, and it stays 1 until reset.
  - PC=0xFFFF with no control → 0x0000, no flag.
- Branch and priority:
  - PC=0x0010, branch_offset=0xFFF8 → 0x0008.
  - Same cycle jump_enable (0x0200) + branch → 0x0200.
  - return+call at depth 1 → pops, depth 0, no push.
- Stall and mid-operation reset:
  - stall 3 cycles with call_enable high → PC and depth unchanged.
  - Reset low in the same cycle as a call → PC=RESET_VECTOR, depth=0.

Source files
------------

// File: rtl/pc_call_stack.sv
// rtl/pc_call_stack.sv - program counter with hardware return-address stack
module pc_call_stack #(
    parameter int          ADDR_WIDTH   = 16,
    parameter int          STACK_DEPTH  = 8,
    parameter int unsigned RESET_VECTOR = 0,
    parameter int unsigned INCREMENT    = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 stall,
    input  logic                                 jump_enable,
    input  logic                                 call_enable,
    input  logic                                 return_enable,
    input  logic                                 branch_enable,
    input  logic [ADDR_WIDTH-1:0]                jump_address,
    input  logic [ADDR_WIDTH-1:0]                branch_offset,
    output logic [ADDR_WIDTH-1:0]                counter_reg,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     stack_depth,
    output logic                                 stack_full,
    output logic                                 stack_empty,
    output logic                                 overflow,
    output logic                                 underflow
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [ADDR_WIDTH-1:0] RV         = ADDR_WIDTH'(RESET_VECTOR);
    localparam logic [ADDR_WIDTH-1:0] INC        = ADDR_WIDTH'(INCREMENT);
    localparam logic [DW-1:0]         FULL_DEPTH = DW'(STACK_DEPTH);
    localparam logic [DW-1:0]         ONE        = DW'(1);

    // Return-address storage; entries at or above stack_depth are stale and never read.
    logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];

    logic [ADDR_WIDTH-1:0] seq_pc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [DW-1:0]         depth_next;
    logic [IW-1:0]         push_idx;
    logic [IW-1:0]         top_idx;
    logic                  push;
    logic                  ovf_set;
    logic                  udf_set;
    logic                  advance;

    // Flags are decoded from the registered depth, so they only move on clock edges.
    assign stack_full  = (stack_depth == FULL_DEPTH);
    assign stack_empty = (stack_depth == '0);

    // Indices are truncated only when the corresponding access cannot happen
    // (push is blocked when full, pop is blocked when empty).
    assign push_idx = IW'(stack_depth);
    assign top_idx  = IW'(stack_depth - ONE);
    assign seq_pc   = counter_reg + INC;

    // A cycle counts only when out of reset and not stalled.
    assign advance = reset && !stall;

    // Resolve the prioritised control set into next PC, next depth and fault/push strobes.
    always_comb begin
        pc_next    = seq_pc;
        depth_next = stack_depth;
        push       = 1'b0;
        ovf_set    = 1'b0;
        udf_set    = 1'b0;
        if (return_enable) begin
            if (!stack_empty) begin
                pc_next    = stack_mem[top_idx];
                depth_next = stack_depth - ONE;
            end else begin
                udf_set = 1'b1;
            end
        end else if (call_enable) begin
            pc_next = jump_address;
            if (!stack_full) begin
                push       = 1'b1;
                depth_next = stack_depth + ONE;
            end else begin
                ovf_set = 1'b1;
            end
        end else if (jump_enable) begin
            pc_next = jump_address;
        end else if (branch_enable) begin
            pc_next = counter_reg + branch_offset;
        end
    end

    // PC, depth and sticky fault registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            counter_reg <= RV;
            stack_depth <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else if (!stall) begin
            counter_reg <= pc_next;
            stack_depth <= depth_next;
            if (ovf_set) overflow  <= 1'b1;
            if (udf_set) underflow <= 1'b1;
        end
    end

    // Stack write port; contents are deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (advance && push) begin
            stack_mem[push_idx] <= seq_pc;
        end
    end

endmodule

// File: tb/tb_pc_call_stack.sv
// tb/tb_pc_call_stack.sv - directed self-checking bench for pc_call_stack
module tb_pc_call_stack;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        jump_enable;
    logic        call_enable;
    logic        return_enable;
    logic        branch_enable;
    logic [15:0] jump_address;
    logic [15:0] branch_offset;
    logic [15:0] counter_reg;
    logic [2:0]  stack_depth;
    logic        stack_full;
    logic        stack_empty;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int passed = 0;

    pc_call_stack #(
        .ADDR_WIDTH  (16),
        .STACK_DEPTH (4),
        .RESET_VECTOR(0),
        .INCREMENT   (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .jump_enable  (jump_enable),
        .call_enable  (call_enable),
        .return_enable(return_enable),
        .branch_enable(branch_enable),
        .jump_address (jump_address),
        .branch_offset(branch_offset),
        .counter_reg  (counter_reg),
        .stack_depth  (stack_depth),
        .stack_full   (stack_full),
        .stack_empty  (stack_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; jump_enable = 0; call_enable = 0;
        return_enable = 0; branch_enable = 0;
    endtask

    initial begin
        reset = 0; idle(); jump_address = '0; branch_offset = '0;
        tick(); tick();
        check("rst_pc", counter_reg, 0);
        check("rst_empty", stack_empty, 1);
        check("rst_depth", stack_depth, 0);
        check("rst_ovf", overflow, 0);
        check("rst_udf", underflow, 0);

        reset = 1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("run_%0d", i), counter_reg, i);
        end

        // Nested call/return
        call_enable = 1; jump_address = 16'h0040; tick();
        check("call1_pc", counter_reg, 16'h0040);
        check("call1_depth", stack_depth, 1);
        idle(); tick();
        check("seq_41", counter_reg, 16'h0041);
        call_enable = 1; jump_address = 16'h0080; tick();
        check("call2_pc", counter_reg, 16'h0080);
        check("call2_depth", stack_depth, 2);
        idle(); return_enable = 1; tick();
        check("ret1_pc", counter_reg, 16'h0042);
        check("ret1_depth", stack_depth, 1);
        tick();
        check("ret2_pc", counter_reg, 16'h0004);
        check("ret2_empty", stack_empty, 1);
        idle();

        // Overflow at depth 4
        reset = 0; tick(); reset = 1;
        check("ovf_start_pc", counter_reg, 0);
        call_enable = 1; jump_address = 16'h0100;
        for (int i = 1; i <= 4; i++) tick();
        check("ovf_full", stack_full, 1);
        check("ovf_flag_before", overflow, 0);
        tick();
        check("ovf_flag", overflow, 1);
        check("ovf_depth", stack_depth, 4);
        check("ovf_pc", counter_reg, 16'h0100);
        idle(); return_enable = 1;
        tick(); check("pop1", counter_reg, 16'h0101);
        tick(); check("pop2", counter_reg, 16'h0101);
        tick(); check("pop3", counter_reg, 16'h0101);
        tick(); check("pop4", counter_reg, 16'h0001);
        check("pop_empty", stack_empty, 1);
        idle();

        // Underflow (reset first so overflow is clear for the wrap check)
        reset = 0; tick(); reset = 1;
        jump_enable = 1; jump_address = 16'h0007; tick();
        check("jmp7", counter_reg, 7);
        idle(); return_enable = 1; tick();
        check("udf_pc", counter_reg, 8);
        check("udf_flag", underflow, 1);
        check("udf_depth", stack_depth, 0);
        idle(); tick();
        check("udf_sticky_pc", counter_reg, 9);
        check("udf_sticky", underflow, 1);

        // Wrap
        jump_enable = 1; jump_address = 16'hFFFF; tick();
        check("jmp_ffff", counter_reg, 16'hFFFF);
        idle(); tick();
        check("wrap_pc", counter_reg, 0);
        check("wrap_noovf", overflow, 0);

        // Branch and priority
        jump_enable = 1; jump_address = 16'h0010; tick();
        idle(); branch_enable = 1; branch_offset = 16'hFFF8; tick();
        check("branch_back", counter_reg, 16'h0008);
        jump_enable = 1; jump_address = 16'h0200; tick();
        check("jump_over_branch", counter_reg, 16'h0200);
        idle(); call_enable = 1; jump_address = 16'h0300; tick();
        check("prio_call_pc", counter_reg, 16'h0300);
        check("prio_call_depth", stack_depth, 1);
        return_enable = 1; jump_address = 16'h0400; tick();
        check("ret_over_call_pc", counter_reg, 16'h0201);
        check("ret_over_call_depth", stack_depth, 0);
        check("ret_over_call_ovf", overflow, 0);

        // Stall with call pending
        idle(); stall = 1; call_enable = 1; jump_address = 16'h0500;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall_pc_%0d", i), counter_reg, 16'h0201);
            check($sformatf("stall_depth_%0d", i), stack_depth, 0);
        end
        idle(); tick();
        check("post_stall_pc", counter_reg, 16'h0202);
        check("post_stall_depth", stack_depth, 0);

        // Reset overrides a call in the same cycle
        call_enable = 1; jump_address = 16'h0500; reset = 0; tick();
        check("rst_call_pc", counter_reg, 0);
        check("rst_call_depth", stack_depth, 0);
        check("rst_call_udf", underflow, 0);
        idle(); reset = 1; tick();
        check("rst_release_pc", counter_reg, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
